// File: rtl/action_sequencer.sv
// Command FIFO feeding a MOVE -> ACT sequencer that drives {move, get, put, interact, throw} with move timeout.
// Optional macro ACTION_RETRY_EN: re-launch the move up to MAX_RETRY times before aborting.
module action_sequencer #(
  parameter int TARGET_W       = 8,
  parameter int FEEDBACK_W     = 8,
  parameter int READY_BIT      = 2,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_RETRY      = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [TARGET_W-1:0]        cmd_target,
  input  logic [1:0]                 cmd_func,
  input  logic [FEEDBACK_W-1:0]      feedbak_sig,
  output logic [TARGET_W-1:0]        target_num,
  output logic [4:0]                 control_data,
  output logic                       busy,
  output logic                       done,
  output logic                       err_timeout,
  output logic [$clog2(DEPTH):0]     q_count
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int TMW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMW-1:0] T_LAST = TMW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_ACT} state_t;
  typedef struct packed {
    logic [TARGET_W-1:0] target;
    logic [1:0]          func;
  } cmd_t;

  cmd_t           fifo_mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  state_t         state, state_nxt;
  cmd_t           active;
  logic [TMW-1:0] timer;
  logic           err_q;

  logic push, pop, start_move, in_move, ready_seen, tmo, retry_ok, relaunch, abort;
  logic unused_fb;

  assign unused_fb  = ^feedbak_sig;
  assign cmd_ready  = count < CW'(DEPTH);
  assign push       = cmd_valid && cmd_ready;
  assign start_move = (state == S_IDLE) && en && (count != '0);
  assign in_move    = (state == S_MOVE);
  assign ready_seen = in_move && en && !relaunch && feedbak_sig[READY_BIT];
  assign tmo        = in_move && en && !relaunch && !feedbak_sig[READY_BIT] && (timer == T_LAST);
  assign abort      = tmo && !retry_ok;
  // The active command stays at the FIFO head until it completes or aborts.
  assign pop        = (state == S_ACT) || abort;

`ifdef ACTION_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 2);
  logic [RW-1:0] retry_cnt;

  assign retry_ok = tmo && (retry_cnt < RW'(MAX_RETRY));

  // relaunch blanks the move bit for one cycle so the traveller starts over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_cnt <= '0;
      relaunch  <= 1'b0;
    end else begin
      relaunch <= retry_ok;
      if (state == S_IDLE)  retry_cnt <= '0;
      else if (retry_ok)    retry_cnt <= retry_cnt + 1'b1;
    end
  end
`else
  localparam int UNUSED_MAX_RETRY = MAX_RETRY;
  assign retry_ok = 1'b0;
  assign relaunch = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{target: cmd_target, func: cmd_func};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= '0;
      timer  <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= abort;
      if (start_move) active <= fifo_mem[rd_ptr];
      if (!in_move || retry_ok)                      timer <= '0;
      else if (en && !relaunch && !ready_seen && !tmo) timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_move) state_nxt = S_MOVE;
      S_MOVE: begin
        if (ready_seen)  state_nxt = S_ACT;
        else if (abort)  state_nxt = S_IDLE;
      end
      S_ACT:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    control_data = 5'b00000;
    target_num   = '0;
    done         = 1'b0;
    case (state)
      S_MOVE: begin
        target_num   = active.target;
        control_data = {en && !relaunch, 4'b0000};
      end
      S_ACT: begin
        target_num = active.target;
        done       = 1'b1;
        case (active.func)
          2'b00:   control_data = 5'b01000;
          2'b01:   control_data = 5'b00100;
          2'b10:   control_data = 5'b00010;
          default: control_data = 5'b00001;
        endcase
      end
      default: ;
    endcase
  end

  assign busy        = (state != S_IDLE) || (count != '0);
  assign err_timeout = err_q;
  assign q_count     = count;
endmodule

// File: tb/tb_action_sequencer.sv
// Bench for action_sequencer: vector table, directed multi-cycle sequences, randomized run vs queue model.
module tb_action_sequencer;
  localparam int TW = 8, FW = 8, RB = 2, DEPTH = 4, TMO = 12;

  logic          clk = 1'b0, rst, en, cmd_valid, cmd_ready;
  logic [TW-1:0] cmd_target, target_num;
  logic [1:0]    cmd_func;
  logic [FW-1:0] feedbak_sig;
  logic [4:0]    control_data;
  logic          busy, done, err_timeout;
  logic [2:0]    q_count;

  action_sequencer #(.TARGET_W(TW), .FEEDBACK_W(FW), .READY_BIT(RB), .DEPTH(DEPTH),
                     .TIMEOUT_CYCLES(TMO), .MAX_RETRY(2)) dut (
    .clk(clk), .rst(rst), .en(en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_target(cmd_target), .cmd_func(cmd_func), .feedbak_sig(feedbak_sig),
    .target_num(target_num), .control_data(control_data), .busy(busy), .done(done),
    .err_timeout(err_timeout), .q_count(q_count));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, move_cyc, done_cnt, err_cnt, mv_state_cyc, last_move, first_err;
  int done_tgt[$];
  logic [4:0] act_pulse[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [19:0] outs();
    return {cmd_ready, busy, done, err_timeout, control_data, target_num, q_count};
  endfunction

  function automatic logic [19:0] pk(input logic rdy, input logic bsy, input logic dn,
                                     input logic er, input logic [4:0] cd,
                                     input logic [7:0] tn, input logic [2:0] qc);
    return {rdy, bsy, dn, er, cd, tn, qc};
  endfunction

  task automatic clr_mon();
    move_cyc = 0; done_cnt = 0; err_cnt = 0; mv_state_cyc = 0;
    last_move = -1; first_err = -1;
    done_tgt.delete(); act_pulse.delete();
  endtask

  task automatic step();
    @(posedge clk); #1;
    cyc++;
    if (control_data == 5'b10000) begin move_cyc++; last_move = cyc; end
    if (target_num != '0 && !done) mv_state_cyc++;
    if (done) begin done_cnt++; done_tgt.push_back(int'(target_num)); act_pulse.push_back(control_data); end
    if (err_timeout) begin err_cnt++; if (first_err < 0) first_err = cyc; end
  endtask

  task automatic drive(input logic v, input logic [7:0] t, input logic [1:0] f,
                       input logic r, input logic e);
    cmd_valid = v; cmd_target = t; cmd_func = f; en = e;
    feedbak_sig = '0; feedbak_sig[RB] = r;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic v; logic [7:0] t; logic [1:0] f; logic r; logic e; logic [19:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [7:0] t, input logic [1:0] f,
                              input logic r, input logic e, input logic [19:0] exp);
    vec_t x;
    x.v = v; x.t = t; x.f = f; x.r = r; x.e = e; x.exp = exp;
    return x;
  endfunction

  // ---------------- reference model ----------------
  typedef struct { logic [7:0] t; logic [1:0] f; } mcmd_t;
  mcmd_t mq[$];
  int    m_ph, m_wait;       // 0 idle, 1 moving, 2 acting
  logic [7:0] m_t;
  logic [1:0] m_f;
  logic  m_err;

  task automatic model_reset();
    mq.delete(); m_ph = 0; m_wait = 0; m_t = '0; m_f = '0; m_err = 1'b0;
  endtask

  task automatic model_edge();
    bit    acc;
    mcmd_t c;
    acc   = cmd_valid && (mq.size() < DEPTH);
    c.t   = cmd_target; c.f = cmd_func;
    m_err = 1'b0;
    case (m_ph)
      0: if (en && mq.size() > 0) begin m_ph = 1; m_t = mq[0].t; m_f = mq[0].f; m_wait = 0; end
      1: if (en && feedbak_sig[RB]) m_ph = 2;
         else if (en) begin
           if (m_wait == TMO - 1) begin void'(mq.pop_front()); m_err = 1'b1; m_ph = 0; end
           else m_wait++;
         end
      default: begin void'(mq.pop_front()); m_ph = 0; end
    endcase
    if (acc) mq.push_back(c);
  endtask

  function automatic logic [19:0] model_out();
    logic [4:0] cd;
    cd = (m_ph == 1) ? (en ? 5'b10000 : 5'b00000) :
         (m_ph == 2) ? 5'(5'd8 >> m_f) : 5'b00000;
    return pk(mq.size() < DEPTH, (m_ph != 0) || (mq.size() > 0), m_ph == 2, m_err, cd,
              (m_ph != 0) ? m_t : 8'd0, 3'(mq.size()));
  endfunction

  initial begin
    vec_t  vecs[18];
    logic [31:0] order;

    rst = 1'b1;
    drive(1'b0, 8'd0, 2'd0, 1'b0, 1'b0);
    #12;
    check("reset_outs", 32'(outs()), 32'(pk(1, 0, 0, 0, 5'b0, 8'd0, 3'd0)));
    rst = 1'b0;

    vecs[0]  = mk(1, 8'd5, 2'd1, 1, 1, pk(1, 1, 0, 0, 5'b00000, 8'd0, 3'd1));
    vecs[1]  = mk(0, 8'd0, 2'd0, 1, 1, pk(1, 1, 0, 0, 5'b10000, 8'd5, 3'd1));
    vecs[2]  = mk(0, 8'd0, 2'd0, 1, 1, pk(1, 1, 1, 0, 5'b00100, 8'd5, 3'd1));
    vecs[3]  = mk(0, 8'd0, 2'd0, 1, 1, pk(1, 0, 0, 0, 5'b00000, 8'd0, 3'd0));
    vecs[4]  = mk(0, 8'd0, 2'd0, 1, 1, pk(1, 0, 0, 0, 5'b00000, 8'd0, 3'd0));
    vecs[5]  = mk(1, 8'd9, 2'd3, 1, 1, pk(1, 1, 0, 0, 5'b00000, 8'd0, 3'd1));
    vecs[6]  = mk(1, 8'd7, 2'd2, 1, 1, pk(1, 1, 0, 0, 5'b10000, 8'd9, 3'd2));
    vecs[7]  = mk(0, 8'd0, 2'd0, 1, 1, pk(1, 1, 1, 0, 5'b00001, 8'd9, 3'd2));
    vecs[8]  = mk(0, 8'd0, 2'd0, 1, 1, pk(1, 1, 0, 0, 5'b00000, 8'd0, 3'd1));
    vecs[9]  = mk(0, 8'd0, 2'd0, 1, 1, pk(1, 1, 0, 0, 5'b10000, 8'd7, 3'd1));
    vecs[10] = mk(0, 8'd0, 2'd0, 1, 1, pk(1, 1, 1, 0, 5'b00010, 8'd7, 3'd1));
    vecs[11] = mk(0, 8'd0, 2'd0, 1, 1, pk(1, 0, 0, 0, 5'b00000, 8'd0, 3'd0));
    vecs[12] = mk(1, 8'd2, 2'd0, 1, 0, pk(1, 1, 0, 0, 5'b00000, 8'd0, 3'd1));
    vecs[13] = mk(0, 8'd0, 2'd0, 1, 0, pk(1, 1, 0, 0, 5'b00000, 8'd0, 3'd1));
    vecs[14] = mk(0, 8'd0, 2'd0, 0, 1, pk(1, 1, 0, 0, 5'b10000, 8'd2, 3'd1));
    vecs[15] = mk(0, 8'd0, 2'd0, 1, 0, pk(1, 1, 0, 0, 5'b00000, 8'd2, 3'd1));
    vecs[16] = mk(0, 8'd0, 2'd0, 1, 1, pk(1, 1, 1, 0, 5'b01000, 8'd2, 3'd1));
    vecs[17] = mk(0, 8'd0, 2'd0, 1, 1, pk(1, 0, 0, 0, 5'b00000, 8'd0, 3'd0));

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].v, vecs[i].t, vecs[i].f, vecs[i].r, vecs[i].e);
      step();
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // ready raised after 10 move cycles
    clr_mon();
    drive(1, 8'd3, 2'd0, 0, 1); step();
    drive(0, 8'd0, 2'd0, 0, 1); step();
    for (int k = 2; k <= 10; k++) step();
    drive(0, 8'd0, 2'd0, 1, 1); step(); step();
    check("late_ready_move_cycles", move_cyc, 10);
    check("late_ready_done_cnt", done_cnt, 1);
    check("late_ready_pulse", (act_pulse.size() > 0) ? 32'(act_pulse[0]) : 32'hff, 32'b01000);
    check("late_ready_busy", 32'(busy), 0);

    // timeout with ready low
    clr_mon();
    drive(1, 8'd4, 2'd1, 0, 1); step();
    drive(0, 8'd0, 2'd0, 0, 1);
    for (int k = 0; k < 20; k++) step();
    check("tmo_move_cycles", move_cyc, TMO);
    check("tmo_err_cnt", err_cnt, 1);
    check("tmo_err_timing", first_err, last_move + 1);
    check("tmo_no_done", done_cnt, 0);
    check("tmo_qcount", 32'(q_count), 0);

    // fill, overflow attempt, drain in order
    clr_mon();
    for (int k = 0; k < 4; k++) begin drive(1, 8'(10 + k), 2'(k), 0, 0); step(); end
    check("full_ready_low", 32'(cmd_ready), 0);
    check("full_qcount", 32'(q_count), 4);
    drive(1, 8'd14, 2'd3, 0, 0); step();
    check("full_push_dropped", 32'(q_count), 4);
    drive(0, 8'd0, 2'd0, 1, 1);
    for (int k = 0; k < 40 && done_cnt < 4; k++) step();
    for (int k = 0; k < 5; k++) step();
    check("full_done_cnt", done_cnt, 4);
    order = '0;
    foreach (done_tgt[i]) order = {order[23:0], 8'(done_tgt[i])};
    check("full_order", order, 32'h0a0b0c0d);
    check("full_drained", 32'(q_count), 0);

    // pause in MOVE shifts the timeout
    clr_mon();
    drive(1, 8'd6, 2'd2, 0, 1); step();
    drive(0, 8'd0, 2'd0, 0, 1); step(); step(); step();
    drive(0, 8'd0, 2'd0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("pause_hold%0d", k), {control_data, target_num}, {5'b00000, 8'd6});
    end
    drive(0, 8'd0, 2'd0, 0, 1);
    for (int k = 0; k < 20; k++) step();
    check("pause_move_cycles", move_cyc, TMO);
    check("pause_state_cycles", mv_state_cyc, TMO + 5);
    check("pause_err_cnt", err_cnt, 1);

    // reset mid-MOVE with 3 queued
    clr_mon();
    for (int k = 0; k < 3; k++) begin drive(1, 8'(20 + k), 2'd1, 0, 0); step(); end
    drive(0, 8'd0, 2'd0, 0, 1); step(); step();
    check("pre_rst_move", 32'(control_data), 32'b10000);
    #3 rst = 1'b1;
    #1 check("rst_async_outs", 32'(outs()), 32'(pk(1, 0, 0, 0, 5'b0, 8'd0, 3'd0)));
    #2 rst = 1'b0;
    drive(0, 8'd0, 2'd0, 1, 1);
    for (int k = 0; k < 20; k++) step();
    check("rst_no_done", done_cnt, 0);
    check("rst_no_err", err_cnt, 0);
    check("rst_qcount", 32'(q_count), 0);

    // randomized run against the queue model
    model_reset();
    for (int k = 0; k < 3000; k++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom), 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 7) != 0));
      feedbak_sig = 8'($urandom);
      feedbak_sig[RB] = ($urandom_range(0, 9) == 0);
      model_edge();
      step();
      check("rand", 32'(outs()), 32'(model_out()));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/action_sequencer.md
Name: action_sequencer

Overview:
- Parametrised successor to the chef action decoder.
- Buffers a queue of (target machine, function) commands and runs each through MOVE → ACT: holds the move request until the feedback ready bit is seen, then issues a single-cycle one-hot action pulse.
- Adds a move timeout with error reporting.
- Sits between the command-script layer and the kitchen/traveller control logic; drives the same 5-bit control_data format {move, get, put, interact, throw}.

Parameters:
- TARGET_W, 8, width of machine/target number.
- FEEDBACK_W, 8, width of kitchen feedback bus.
- READY_BIT, 2, index in feedback of "chef in front of target machine".
- DEPTH, 4, command FIFO depth (power of 2, ≥2).
- TIMEOUT_CYCLES, 1000, max cycles in MOVE before abort (≥2).
- MAX_RETRY, 2, extra move attempts after timeout (only used with ACTION_RETRY_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global enable; low = pause.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept; equals (count < DEPTH).
- cmd_target  in  TARGET_W  target machine number.
- cmd_func  in  2  00 GET, 01 PUT, 10 INTERACT, 11 THROW.
- feedbak_sig  in  FEEDBACK_W  current kitchen state.
- target_num  out  TARGET_W  target of the active command; 0 when IDLE.
- control_data  out  5  {move_en, get_en, put_en, interact_en, throw_en}.
- busy  out  1  FSM not IDLE or FIFO non-empty.
- done  out  1  one-cycle pulse, command completed.
- err_timeout  out  1  one-cycle pulse, command aborted on timeout.
- q_count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - FSM goes to IDLE; FIFO empties (q_count 0); timer and retry count clear.
  - Outputs: control_data 0, target_num 0, done 0, err_timeout 0, busy 0, cmd_ready 1.
  - Reset mid-operation discards all queued and active commands with no done or err pulse.
- Push: cmd_valid && cmd_ready at a rising edge.
  - Push while full is ignored.
  - Simultaneous push and pop when full: push is rejected, because cmd_ready was low that cycle.
  - Simultaneous push and pop when not full: count is unchanged.
- FSM states IDLE, MOVE, ACT:
  - IDLE → MOVE when en=1 and FIFO non-empty. The head is latched into the active target/func registers; timer clears.
  - MOVE: control_data = 10000, target_num = active target.
    - If en=1 and feedbak_sig[READY_BIT]=1 is sampled, go to ACT.
    - Else if en=1 and timer == TIMEOUT_CYCLES-1, abort.
    - Else the timer increments while en=1.
    - Move is asserted for at least 1 cycle, even if ready is already high.
  - ACT: lasts exactly 1 cycle.
    - control_data = one-hot of func (GET 01000, PUT 00100, INTERACT 00010, THROW 00001), move bit 0.
    - done=1; FIFO head popped at the edge; next state IDLE.
    - ACT completes even if en drops during it.
  - Abort: FIFO head popped, err_timeout=1 for the following cycle, next state IDLE.
- en=0 pause: the FSM holds its state in IDLE and MOVE; control_data is forced to 00000 and the timer is frozen. Queue pushes are still accepted.
- Latency, from an empty FIFO with en=1:
  - Push at edge N → MOVE visible after edge N+1.
  - Ready high throughout → ACT after edge N+2 → IDLE after N+3.
  - Minimum 3 cycles per command.
- All outputs are decoded from registered state; there is no combinational path from feedbak_sig, cmd_* or en to control_data, done or err_timeout. en gating of control_data is the single exception.
- Timer width is $clog2(TIMEOUT_CYCLES)+1; it never wraps, because the timeout fires first.

Optional Feature:
- Macro ACTION_RETRY_EN.
- Defined: on timeout, if retry_cnt < MAX_RETRY, stay in MOVE, clear the timer, increment retry_cnt, and pulse control_data to 00000 for one cycle so the traveller re-launches. There is no err and no pop. When retries are exhausted, abort as normal. retry_cnt clears on every IDLE→MOVE.
- Undefined: the first timeout aborts immediately; no retry logic is synthesised.

Test Plan:
- Push (target 5, PUT) with ready held 1 → control_data 10000 for 1 cycle with target_num 5, then 00100 plus done for 1 cycle, then IDLE with busy 0.
- Push (target 3, GET); raise ready after 10 cycles → move held 10 cycles, then a single 01000 pulse; done count 1.
- TIMEOUT_CYCLES=8, ready held 0, macro undefined → move asserted 8 cycles, then err_timeout pulse, q_count decrements, no done.
- Push 4 commands back-to-back, then push a 5th while full → cmd_ready 0; the 5th is dropped; the 4 commands complete in order with 4 done pulses.
- In MOVE, drop en for 5 cycles → control_data 00000 and timer frozen; restore en → move resumes and the timeout shifts by 5 cycles.
- Assert rst mid-MOVE with 3 commands queued → outputs 0 immediately, q_count 0, no done or err afterwards.
